// File: rtl/nn_pkg.sv
// Shared types for the layer-output serializer: the FSM state encoding.
package nn_pkg;

  typedef enum logic [2:0] {
    COLLECT,
    FULL,
    START,
    STREAM,
    DONE,
    HOLD
  } ser_state_t;

endpackage

// File: rtl/activation_capture_bank.sv
// Per-neuron activation capture registers with first-capture-wins mask and an indexed read port.
module activation_capture_bank
  import nn_pkg::*;
#(
  parameter int numNeurons = 30,
  parameter int dataWidth  = 8,
  localparam int IDX_W     = $clog2(numNeurons)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            clear,
  input  logic                            enable,
  input  logic [numNeurons-1:0]           valid,
  input  logic [numNeurons*dataWidth-1:0] data_bus,
  input  logic [IDX_W-1:0]                rd_idx,
  output logic [numNeurons-1:0]           mask,
  output logic [dataWidth-1:0]            rd_data
);

  logic [dataWidth-1:0] regs [numNeurons];

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      for (int n = 0; n < numNeurons; n++) regs[n] <= '0;
      mask <= '0;
    end else if (enable) begin
      // A set mask bit freezes that neuron's value until the next clear.
      for (int n = 0; n < numNeurons; n++) begin
        if (valid[n] && !mask[n]) begin
          regs[n] <= data_bus[n*dataWidth +: dataWidth];
          mask[n] <= 1'b1;
        end
      end
    end
  end

  assign rd_data = regs[rd_idx];

endmodule

// File: rtl/layer_output_serializer.sv
// Collects one layer's activations, then replays them serially to the next layer with a start pulse.
module layer_output_serializer
  import nn_pkg::*;
#(
  parameter int numNeurons  = 30,
  parameter int dataWidth   = 8,
  parameter int layerNumber = 0
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [numNeurons*dataWidth-1:0] neuronOutBus,
  input  logic [numNeurons-1:0]           neuronOutValid,
  input  logic                            frameStart,
  input  logic                            nextReady,
  output logic [dataWidth-1:0]            layerOut,
  output logic                            layerOutValid,
  output logic                            layerOutActive,
  output logic                            layerDone,
  output logic [numNeurons-1:0]           capturedMask
);

  localparam int IDX_W = $clog2(numNeurons);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(numNeurons - 1);

  if (numNeurons < 2 || layerNumber < 0) begin : g_param_check
    $error("layer_output_serializer layer %0d: numNeurons must be >= 2", layerNumber);
  end

  ser_state_t           state;
  logic [IDX_W-1:0]     idx;
  logic [IDX_W-1:0]     rd_idx;
  logic [dataWidth-1:0] rd_data;
  logic                 pending;
  logic                 capture_en;
  logic                 clear_req;
  logic                 all_captured;

  activation_capture_bank #(
    .numNeurons(numNeurons),
    .dataWidth (dataWidth)
  ) u_bank (
    .clk     (clk),
    .reset   (reset),
    .clear   (clear_req),
    .enable  (capture_en),
    .valid   (neuronOutValid),
    .data_bus(neuronOutBus),
    .rd_idx  (rd_idx),
    .mask    (capturedMask),
    .rd_data (rd_data)
  );

  always_comb begin
    capture_en   = (state == COLLECT) && !frameStart;
    clear_req    = (frameStart && (state inside {COLLECT, FULL, HOLD, DONE}))
                || ((state == DONE) && pending);
    all_captured = &(capturedMask | neuronOutValid);
    // Prefetch the element that goes out on the next cycle.
    rd_idx = '0;
    if (state == STREAM && idx != LAST_IDX) rd_idx = idx + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= COLLECT;
      idx            <= '0;
      pending        <= 1'b0;
      layerOut       <= '0;
      layerOutValid  <= 1'b0;
      layerOutActive <= 1'b0;
      layerDone      <= 1'b0;
    end else begin
      layerOutValid <= 1'b0;
      layerDone     <= 1'b0;
      case (state)
        COLLECT: begin
          if (frameStart) layerOut <= '0;
          else if (all_captured) state <= FULL;
        end
        FULL: begin
          if (frameStart) begin
            state    <= COLLECT;
            layerOut <= '0;
          end else if (nextReady) begin
            state         <= START;
            layerOutValid <= 1'b1;
          end
        end
        START: begin
          if (frameStart) pending <= 1'b1;
          idx            <= '0;
          layerOut       <= rd_data;
          layerOutActive <= 1'b1;
          state          <= STREAM;
        end
        STREAM: begin
          // A new frame mid-stream is deferred until the stream has finished.
          if (frameStart) pending <= 1'b1;
          if (idx == LAST_IDX) begin
            layerOutActive <= 1'b0;
            layerDone      <= 1'b1;
            state          <= DONE;
          end else begin
            idx      <= idx + 1'b1;
            layerOut <= rd_data;
          end
        end
        DONE: begin
          if (frameStart || pending) begin
            state    <= COLLECT;
            pending  <= 1'b0;
            layerOut <= '0;
          end else begin
            state <= HOLD;
          end
        end
        HOLD: begin
          if (frameStart) begin
            state    <= COLLECT;
            layerOut <= '0;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule
